// File: rtl/bus_region_sequencer.sv
// 68030 local-bus cycle sequencer: region decode, chip enables, programmable
// wait/ext-ack timing, DSACK port sizing and BERR on timeout or no match.
//
// Ports:
//   sysClk, sysRESETn         clock, async active-low reset
//   cpuASn, cpuRWn, cpuFC     CPU strobe, direction, function code
//   cpuAddrHi                 A[31:32-ADDR_W]
//   extACKn                   per-region external ack (active low)
//   cfgWE, cfgSel, cfgData    table write {ciin, size[1:0], ext, wait}
//   regCEn                    per-region chip enable (active low)
//   cpuDSACKn, dsackOE        DSACK value and its output enable
//   cpuBERRn, cpuCIINn        bus error, cache inhibit (active low)
//   busy                      sequencer not idle
module bus_region_sequencer #(
  parameter int NREG = 4,
  parameter int ADDR_W = 8,
  parameter logic [NREG*ADDR_W-1:0] REG_MATCH = '0,
  parameter logic [NREG*ADDR_W-1:0] REG_MASK = '1,
  parameter int WAIT_W = 4,
  parameter int TO_W = 8,
  parameter logic [TO_W-1:0] TO_LIMIT = '1,
  parameter bit BERR_NOMATCH = 1'b1,
  localparam int SEL_W = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              sysClk,
  input  logic              sysRESETn,
  input  logic              cpuASn,
  input  logic              cpuRWn,
  input  logic [2:0]        cpuFC,
  input  logic [ADDR_W-1:0] cpuAddrHi,
  input  logic [NREG-1:0]   extACKn,
  input  logic              cfgWE,
  input  logic [SEL_W-1:0]  cfgSel,
  input  logic [WAIT_W+3:0] cfgData,
  output logic [NREG-1:0]   regCEn,
  output logic [1:0]        cpuDSACKn,
  output logic              dsackOE,
  output logic              cpuBERRn,
  output logic              cpuCIINn,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    BERR = 2'd3
  } state_t;

  state_t state, stateNext;

  logic [WAIT_W-1:0] tWait [NREG];
  logic              tExt  [NREG];
  logic [1:0]        tSize [NREG];
  logic              tCiin [NREG];

  logic [SEL_W-1:0]  idx;
  logic              latExt;
  logic [1:0]        latSize;
  logic              latCiin;
  logic [WAIT_W-1:0] waitCnt;
  logic [TO_W-1:0]   toCnt;
  logic              negPhase;

  logic              hitAny;
  logic [SEL_W-1:0]  hitIdx;
  logic              ackNow;
  logic              loadEntry;
  logic              unusedRw;

  assign unusedRw = cpuRWn;

  // Descending scan so the lowest-index hit is the last assignment.
  always_comb begin
    hitAny = 1'b0;
    hitIdx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (((cpuAddrHi ^ REG_MATCH[i*ADDR_W +: ADDR_W])
           & REG_MASK[i*ADDR_W +: ADDR_W]) == '0) begin
        hitAny = 1'b1;
        hitIdx = SEL_W'(i);
      end
    end
  end

  assign ackNow = latExt ? ~extACKn[idx] : (waitCnt == '0);

  always_ff @(posedge sysClk or negedge sysRESETn) begin
    if (!sysRESETn) begin
      for (int i = 0; i < NREG; i++) begin
        tWait[i] <= '1;
        tExt[i]  <= 1'b0;
        tSize[i] <= 2'b01;
        tCiin[i] <= 1'b1;
      end
    end else if (cfgWE && (int'(cfgSel) < NREG)) begin
      tWait[cfgSel] <= cfgData[WAIT_W-1:0];
      tExt[cfgSel]  <= cfgData[WAIT_W];
      tSize[cfgSel] <= cfgData[WAIT_W+2:WAIT_W+1];
      tCiin[cfgSel] <= cfgData[WAIT_W+3];
    end
  end

  always_ff @(posedge sysClk or negedge sysRESETn) begin
    if (!sysRESETn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    loadEntry = 1'b0;
    regCEn    = '1;
    cpuDSACKn = 2'b11;
    dsackOE   = 1'b0;
    cpuBERRn  = 1'b1;
    cpuCIINn  = 1'b1;
    unique case (state)
      IDLE: begin
        dsackOE = negPhase;
        if (!cpuASn && cpuFC != 3'b111) begin
          if (hitAny) begin
            stateNext = WAIT;
            loadEntry = 1'b1;
          end else if (BERR_NOMATCH) begin
            stateNext = BERR;
          end
        end
      end
      WAIT: begin
        regCEn[idx] = 1'b0;
        cpuCIINn = ~latCiin;
        if (cpuASn) begin
          stateNext = IDLE;
        end else if (ackNow) begin
          stateNext = ACK;
        end else if (toCnt == '0) begin
          stateNext = BERR;
        end
      end
      ACK: begin
        regCEn[idx] = 1'b0;
        dsackOE = 1'b1;
        unique case (latSize)
          2'b00:   cpuDSACKn = 2'b00;
          2'b10:   cpuDSACKn = 2'b01;
          default: cpuDSACKn = 2'b10;
        endcase
        if (cpuASn) begin
          stateNext = IDLE;
        end
      end
      BERR: begin
        cpuBERRn = 1'b0;
        if (cpuASn) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge sysClk or negedge sysRESETn) begin
    if (!sysRESETn) begin
      idx      <= '0;
      latExt   <= 1'b0;
      latSize  <= 2'b01;
      latCiin  <= 1'b1;
      waitCnt  <= '0;
      toCnt    <= '0;
      negPhase <= 1'b0;
    end else begin
      // One IDLE cycle of driven-high DSACK after a completed cycle.
      negPhase <= (state == ACK) && (stateNext == IDLE);
      if (loadEntry) begin
        idx     <= hitIdx;
        latExt  <= tExt[hitIdx];
        latSize <= tSize[hitIdx];
        latCiin <= tCiin[hitIdx];
        waitCnt <= tWait[hitIdx];
        toCnt   <= TO_LIMIT;
      end else if (state == WAIT) begin
        if (!latExt && waitCnt != '0) begin
          waitCnt <= waitCnt - 1'b1;
        end
        if (toCnt != '0) begin
          toCnt <= toCnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_region_sequencer.sv
// Self-checking bench for bus_region_sequencer: directed scenarios plus
// randomized cycles scored against a region-table reference model.
module tb_bus_region_sequencer;

  localparam int TO_LIM = 255;
  localparam logic [31:0] MATCH = {8'h00, 8'h30, 8'h20, 8'h10};
  localparam logic [31:0] MASK  = {8'hC0, 8'hFF, 8'hFF, 8'hF0};

  logic       sysClk = 1'b0;
  logic       sysRESETn = 1'b0;
  logic       cpuASn = 1'b1;
  logic       cpuRWn = 1'b1;
  logic [2:0] cpuFC = 3'b101;
  logic [7:0] cpuAddrHi = 8'h00;
  logic [3:0] extACKn = 4'hF;
  logic       cfgWE = 1'b0;
  logic [1:0] cfgSel = 2'd0;
  logic [7:0] cfgData = 8'h00;

  logic [3:0] regCEn;
  logic [1:0] cpuDSACKn;
  logic       dsackOE, cpuBERRn, cpuCIINn, busy;
  logic [3:0] nRegCEn;
  logic [1:0] nDSACKn;
  logic       nDsackOE, nBERRn, nCIINn, nBusy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rMatch [4] = '{8'h10, 8'h20, 8'h30, 8'h00};
  logic [7:0] rMask  [4] = '{8'hF0, 8'hFF, 8'hFF, 8'hC0};
  int  mWait [4];
  bit  mExt  [4];
  int  mSize [4];
  bit  mCiin [4];

  bus_region_sequencer #(
    .NREG(4), .ADDR_W(8), .REG_MATCH(MATCH), .REG_MASK(MASK),
    .WAIT_W(4), .TO_W(8), .TO_LIMIT(8'hFF), .BERR_NOMATCH(1'b1)
  ) dut (
    .sysClk(sysClk), .sysRESETn(sysRESETn), .cpuASn(cpuASn),
    .cpuRWn(cpuRWn), .cpuFC(cpuFC), .cpuAddrHi(cpuAddrHi),
    .extACKn(extACKn), .cfgWE(cfgWE), .cfgSel(cfgSel),
    .cfgData(cfgData), .regCEn(regCEn), .cpuDSACKn(cpuDSACKn),
    .dsackOE(dsackOE), .cpuBERRn(cpuBERRn), .cpuCIINn(cpuCIINn),
    .busy(busy)
  );

  bus_region_sequencer #(
    .NREG(4), .ADDR_W(8), .REG_MATCH(MATCH), .REG_MASK(MASK),
    .WAIT_W(4), .TO_W(8), .TO_LIMIT(8'hFF), .BERR_NOMATCH(1'b0)
  ) dutNm (
    .sysClk(sysClk), .sysRESETn(sysRESETn), .cpuASn(cpuASn),
    .cpuRWn(cpuRWn), .cpuFC(cpuFC), .cpuAddrHi(cpuAddrHi),
    .extACKn(extACKn), .cfgWE(cfgWE), .cfgSel(cfgSel),
    .cfgData(cfgData), .regCEn(nRegCEn), .cpuDSACKn(nDSACKn),
    .dsackOE(nDsackOE), .cpuBERRn(nBERRn), .cpuCIINn(nCIINn),
    .busy(nBusy)
  );

  always #5 sysClk = ~sysClk;

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mWait[i] = 15; mExt[i] = 0; mSize[i] = 1; mCiin[i] = 1;
    end
  endtask

  function automatic int model_region(input logic [7:0] a,
                                      input logic [2:0] fc);
    if (fc == 3'b111) return -2;
    for (int i = 0; i < 4; i++)
      if (((a ^ rMatch[i]) & rMask[i]) == 8'h00) return i;
    return -1;
  endfunction

  function automatic logic [1:0] ds_for(input int size);
    case (size)
      0: return 2'b00;
      2: return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  // Expected edge numbers counted from AS assertion (edge 1 samples AS).
  task automatic predict(input logic [7:0] a, input logic [2:0] fc,
                         input int d, output int eCe, output int eAck,
                         output int eBerr, output logic [3:0] eV,
                         output logic [1:0] eDs, output logic eCi);
    int r;
    r = model_region(a, fc);
    eCe = -1; eAck = -1; eBerr = -1; eV = 4'hF; eDs = 2'b11; eCi = 1'b1;
    if (r == -1) begin
      eBerr = 1;
    end else if (r >= 0) begin
      eCe = 1; eV[r] = 1'b0; eCi = ~mCiin[r];
      if (!mExt[r]) begin
        eAck = mWait[r] + 2; eDs = ds_for(mSize[r]);
      end else if (d >= 0 && d + 2 <= TO_LIM + 2) begin
        eAck = d + 2; eDs = ds_for(mSize[r]);
      end else begin
        eBerr = TO_LIM + 2;
      end
    end
  endtask

  task automatic cfg_write(input int sel, input logic [7:0] data);
    @(negedge sysClk);
    cfgSel = 2'(sel); cfgData = data; cfgWE = 1'b1;
    @(negedge sysClk);
    cfgWE = 1'b0;
    mWait[sel] = data[3:0]; mExt[sel] = data[4];
    mSize[sel] = data[6:5]; mCiin[sel] = data[7];
  endtask

  task automatic run_cycle(input logic [7:0] a, input logic [2:0] fc,
                           input int d, input int maxE, input int wrAt,
                           input logic [7:0] wrData,
                           output int ceE, output logic [3:0] ceV,
                           output int ackE, output logic [1:0] dsV,
                           output int berrE, output logic ciObs,
                           output bit busySeen, output bit nmActive);
    int r;
    r = model_region(a, fc);
    ceE = -1; ackE = -1; berrE = -1; ceV = 4'hF; dsV = 2'b11;
    ciObs = 1'b1; busySeen = 0; nmActive = 0;
    @(negedge sysClk);
    cpuAddrHi = a; cpuFC = fc; cpuASn = 1'b0;
    for (int k = 1; k <= maxE; k++) begin
      @(posedge sysClk); #1;
      if (busy) busySeen = 1;
      if (nBusy || !nBERRn) nmActive = 1;
      if (ceE < 0 && regCEn != 4'hF) begin
        ceE = k; ceV = regCEn; ciObs = cpuCIINn;
      end
      cfgWE = 1'b0;
      if (k == wrAt) begin
        cfgSel = 2'd0; cfgData = wrData; cfgWE = 1'b1;
      end
      if (dsackOE && cpuDSACKn != 2'b11) begin
        ackE = k; dsV = cpuDSACKn; break;
      end
      if (!cpuBERRn) begin
        berrE = k; break;
      end
      if (d >= 0 && ceE >= 0 && r >= 0 && k == ceE + d) extACKn[r] = 1'b0;
    end
    cfgWE = 1'b0;
  endtask

  task automatic end_cycle();
    cpuASn = 1'b1; extACKn = 4'hF;
  endtask

  task automatic test_reset();
    sysRESETn = 1'b0;
    repeat (2) @(posedge sysClk);
    #1;
    vectors++; if (regCEn !== 4'hF) begin miscompares++; $display("FAIL rst_ce got %h want F", regCEn); end
    vectors++; if (cpuDSACKn !== 2'b11) begin miscompares++; $display("FAIL rst_ds got %b want 11", cpuDSACKn); end
    vectors++; if (dsackOE !== 1'b0) begin miscompares++; $display("FAIL rst_oe got %b want 0", dsackOE); end
    vectors++; if (cpuBERRn !== 1'b1) begin miscompares++; $display("FAIL rst_berr got %b want 1", cpuBERRn); end
    vectors++; if (cpuCIINn !== 1'b1) begin miscompares++; $display("FAIL rst_ciin got %b want 1", cpuCIINn); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
    @(negedge sysClk);
    sysRESETn = 1'b1;
    model_reset();
  endtask

  task automatic test_internal();
    int ce, ack, be; logic [3:0] v; logic [1:0] ds; logic ci; bit bs, nm;
    cfg_write(0, 8'h83);
    run_cycle(8'h10, 3'b101, -1, 40, -1, 8'h00, ce, v, ack, ds, be, ci, bs, nm);
    vectors++; if (ce !== 1) begin miscompares++; $display("FAIL int_ce_edge got %0d want 1", ce); end
    vectors++; if (v !== 4'hE) begin miscompares++; $display("FAIL int_ce_vec got %h want E", v); end
    vectors++; if (ack !== 5) begin miscompares++; $display("FAIL int_ack_edge got %0d want 5", ack); end
    vectors++; if (ds !== 2'b00) begin miscompares++; $display("FAIL int_ds got %b want 00", ds); end
    vectors++; if (ci !== 1'b0) begin miscompares++; $display("FAIL int_ciin got %b want 0", ci); end
    end_cycle();
    @(posedge sysClk); #1;
    vectors++; if (dsackOE !== 1'b1 || cpuDSACKn !== 2'b11) begin miscompares++; $display("FAIL int_negate got oe=%b ds=%b want oe=1 ds=11", dsackOE, cpuDSACKn); end
    vectors++; if (regCEn !== 4'hF || busy !== 1'b0) begin miscompares++; $display("FAIL int_release got ce=%h busy=%b want F 0", regCEn, busy); end
    @(posedge sysClk); #1;
    vectors++; if (dsackOE !== 1'b0) begin miscompares++; $display("FAIL int_oe_off got %b want 0", dsackOE); end
  endtask

  task automatic test_external();
    int ce, ack, be; logic [3:0] v; logic [1:0] ds; logic ci; bit bs, nm;
    cfg_write(1, 8'h50);
    run_cycle(8'h20, 3'b101, 6, 40, -1, 8'h00, ce, v, ack, ds, be, ci, bs, nm);
    vectors++; if (v !== 4'hD) begin miscompares++; $display("FAIL ext_ce_vec got %h want D", v); end
    vectors++; if (ack !== 8) begin miscompares++; $display("FAIL ext_ack_edge got %0d want 8", ack); end
    vectors++; if (ds !== 2'b01) begin miscompares++; $display("FAIL ext_ds got %b want 01", ds); end
    vectors++; if (be !== -1) begin miscompares++; $display("FAIL ext_berr got %0d want -1", be); end
    end_cycle();
    repeat (2) @(posedge sysClk);
  endtask

  task automatic test_timeout();
    int ce, ack, be; logic [3:0] v; logic [1:0] ds; logic ci; bit bs, nm;
    cfg_write(2, 8'h10);
    run_cycle(8'h30, 3'b110, -1, 300, -1, 8'h00, ce, v, ack, ds, be, ci, bs, nm);
    vectors++; if (v !== 4'hB) begin miscompares++; $display("FAIL to_ce_vec got %h want B", v); end
    vectors++; if (be !== TO_LIM + 2) begin miscompares++; $display("FAIL to_berr_edge got %0d want %0d", be, TO_LIM + 2); end
    vectors++; if (ack !== -1) begin miscompares++; $display("FAIL to_ack got %0d want -1", ack); end
    #1;
    vectors++; if (regCEn !== 4'hF || dsackOE !== 1'b0) begin miscompares++; $display("FAIL to_berr_out got ce=%h oe=%b want F 0", regCEn, dsackOE); end
    end_cycle();
    @(posedge sysClk); #1;
    vectors++; if (cpuBERRn !== 1'b1 || busy !== 1'b0 || dsackOE !== 1'b0) begin miscompares++; $display("FAIL to_release got berr=%b busy=%b oe=%b want 1 0 0", cpuBERRn, busy, dsackOE); end
  endtask

  task automatic test_overlap_nomatch();
    int ce, ack, be; logic [3:0] v; logic [1:0] ds; logic ci; bit bs, nm;
    run_cycle(8'h15, 3'b001, -1, 40, -1, 8'h00, ce, v, ack, ds, be, ci, bs, nm);
    vectors++; if (v !== 4'hE) begin miscompares++; $display("FAIL ovl_ce_vec got %h want E", v); end
    end_cycle(); @(posedge sysClk);
    run_cycle(8'h05, 3'b001, -1, 40, -1, 8'h00, ce, v, ack, ds, be, ci, bs, nm);
    vectors++; if (v !== 4'h7) begin miscompares++; $display("FAIL r3_ce_vec got %h want 7", v); end
    vectors++; if (ack !== 17 || ds !== 2'b10) begin miscompares++; $display("FAIL r3_ack got edge=%0d ds=%b want 17 10", ack, ds); end
    end_cycle(); @(posedge sysClk);
    run_cycle(8'h80, 3'b010, -1, 12, -1, 8'h00, ce, v, ack, ds, be, ci, bs, nm);
    vectors++; if (be !== 1 || ce !== -1) begin miscompares++; $display("FAIL nm_berr got berr=%0d ce=%0d want 1 -1", be, ce); end
    vectors++; if (nm !== 1'b0) begin miscompares++; $display("FAIL nm_ignore got active=%b want 0", nm); end
    end_cycle(); @(posedge sysClk);
  endtask

  task automatic test_cpu_space();
    int ce, ack, be; logic [3:0] v; logic [1:0] ds; logic ci; bit bs, nm;
    run_cycle(8'h10, 3'b111, -1, 12, -1, 8'h00, ce, v, ack, ds, be, ci, bs, nm);
    vectors++; if (ce !== -1 || ack !== -1 || be !== -1) begin miscompares++; $display("FAIL cpusp got ce=%0d ack=%0d berr=%0d want none", ce, ack, be); end
    vectors++; if (bs !== 1'b0) begin miscompares++; $display("FAIL cpusp_busy got %b want 0", bs); end
    end_cycle(); @(posedge sysClk);
  endtask

  task automatic test_inflight_write();
    int ce, ack, be, eCe, eAck, eBe; logic [3:0] v, eV;
    logic [1:0] ds, eDs; logic ci, eCi; bit bs, nm;
    run_cycle(8'h12, 3'b101, -1, 40, 2, 8'hC0, ce, v, ack, ds, be, ci, bs, nm);
    vectors++; if (ack !== 5 || ds !== 2'b00) begin miscompares++; $display("FAIL inflight got edge=%0d ds=%b want 5 00", ack, ds); end
    end_cycle(); @(posedge sysClk);
    mWait[0] = 0; mExt[0] = 0; mSize[0] = 2; mCiin[0] = 1;
    predict(8'h12, 3'b101, -1, eCe, eAck, eBe, eV, eDs, eCi);
    run_cycle(8'h12, 3'b101, -1, 40, -1, 8'h00, ce, v, ack, ds, be, ci, bs, nm);
    vectors++; if (ack !== eAck || ds !== eDs) begin miscompares++; $display("FAIL newentry got edge=%0d ds=%b want %0d %b", ack, ds, eAck, eDs); end
    end_cycle(); @(posedge sysClk);
  endtask

  task automatic test_abort();
    int ce, ack, be; logic [3:0] v; logic [1:0] ds; logic ci; bit bs, nm;
    run_cycle(8'h04, 3'b101, -1, 4, -1, 8'h00, ce, v, ack, ds, be, ci, bs, nm);
    end_cycle();
    @(posedge sysClk); #1;
    vectors++; if (busy !== 1'b0 || dsackOE !== 1'b0 || regCEn !== 4'hF) begin miscompares++; $display("FAIL abort got busy=%b oe=%b ce=%h want 0 0 F", busy, dsackOE, regCEn); end
  endtask

  task automatic test_back_to_back();
    int ce, ack, be, eCe, eAck, eBe, d; logic [3:0] v, eV;
    logic [1:0] ds, eDs; logic ci, eCi; bit bs, nm;
    logic [7:0] a; logic [2:0] fc;
    logic [2:0] fcs [5] = '{3'b001, 3'b010, 3'b101, 3'b110, 3'b111};
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0)
        cfg_write($urandom_range(0, 3), 8'($urandom));
      case ($urandom_range(0, 4))
        0: a = 8'h10 + 8'($urandom_range(0, 15));
        1: a = 8'h20;
        2: a = 8'h30;
        3: a = 8'($urandom_range(0, 63));
        default: a = 8'h40 + 8'($urandom_range(0, 191));
      endcase
      fc = fcs[$urandom_range(0, 4)];
      d = $urandom_range(0, 12);
      if (d == 12) d = -1;
      predict(a, fc, d, eCe, eAck, eBe, eV, eDs, eCi);
      run_cycle(a, fc, d, (fc == 3'b111) ? 12 : 300, -1, 8'h00,
                ce, v, ack, ds, be, ci, bs, nm);
      vectors++; if (v !== eV || ce !== eCe) begin miscompares++; $display("FAIL rnd_ce a=%h got %h@%0d want %h@%0d", a, v, ce, eV, eCe); end
      vectors++; if (ack !== eAck || ds !== eDs) begin miscompares++; $display("FAIL rnd_ack a=%h got %0d/%b want %0d/%b", a, ack, ds, eAck, eDs); end
      vectors++; if (be !== eBe) begin miscompares++; $display("FAIL rnd_berr a=%h got %0d want %0d", a, be, eBe); end
      vectors++; if (ci !== eCi) begin miscompares++; $display("FAIL rnd_ciin a=%h got %b want %b", a, ci, eCi); end
      end_cycle();
      @(posedge sysClk); #1;
      vectors++; if (busy !== 1'b0 || dsackOE !== (eAck > 0)) begin miscompares++; $display("FAIL rnd_idle got busy=%b oe=%b want 0 %b", busy, dsackOE, eAck > 0); end
    end
  endtask

  task automatic test_reset_mid();
    int ce, ack, be; logic [3:0] v; logic [1:0] ds; logic ci; bit bs, nm;
    cfg_write(0, 8'h02);
    cfg_write(3, 8'h21);
    @(negedge sysClk);
    cpuAddrHi = 8'h10; cpuFC = 3'b101; cpuASn = 1'b0;
    repeat (2) @(posedge sysClk);
    #2 sysRESETn = 1'b0;
    #1;
    vectors++; if (regCEn !== 4'hF || busy !== 1'b0) begin miscompares++; $display("FAIL midrst_ce got ce=%h busy=%b want F 0", regCEn, busy); end
    vectors++; if (dsackOE !== 1'b0 || cpuDSACKn !== 2'b11 || cpuBERRn !== 1'b1 || cpuCIINn !== 1'b1) begin miscompares++; $display("FAIL midrst_out got oe=%b ds=%b berr=%b ci=%b", dsackOE, cpuDSACKn, cpuBERRn, cpuCIINn); end
    cpuASn = 1'b1;
    @(negedge sysClk);
    sysRESETn = 1'b1;
    model_reset();
    run_cycle(8'h10, 3'b101, -1, 40, -1, 8'h00, ce, v, ack, ds, be, ci, bs, nm);
    vectors++; if (ack !== 17 || ds !== 2'b10) begin miscompares++; $display("FAIL midrst_dflt got %0d/%b want 17/10", ack, ds); end
    vectors++; if (ci !== 1'b0) begin miscompares++; $display("FAIL midrst_ciin got %b want 0", ci); end
    end_cycle(); @(posedge sysClk);
    run_cycle(8'h05, 3'b101, 3, 40, -1, 8'h00, ce, v, ack, ds, be, ci, bs, nm);
    vectors++; if (ack !== 17 || ds !== 2'b10) begin miscompares++; $display("FAIL midrst_r3 got %0d/%b want 17/10", ack, ds); end
    end_cycle(); @(posedge sysClk);
  endtask

  initial begin
    test_reset();
    test_internal();
    test_external();
    test_timeout();
    test_overlap_nomatch();
    test_cpu_space();
    test_inflight_write();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
